// File: rtl/aes_vector_sequencer.sv
// Purpose  : walks a table of AES test vectors and runs one encrypt/decrypt pass per vector.
//            Each run's ciphertext and recovered plaintext are checked, and pass/fail/timeout is recorded per vector.
// Latency  : vector memory is read one cycle after vec_addr_o. Per-vector overhead outside RUN is 3 cycles.
// Backpress: there is no handshake. start_i is ignored while busy, and a stalled run is abandoned after TIMEOUT cycles.
// Ports    : clk/reset (async, active-high); start_i/loop_mode_i control;
//            vec_* vector memory read port; dut_* drive/result of the SPI master;
//            enc_pass_o/dec_pass_o/timeout_flags_o per-vector bitmaps;
//            busy_o/done_o/all_pass_o/error_sticky_o/iter_count_o status.
module aes_vector_sequencer #(
   parameter int NUM_VEC = 8,
   parameter int IDX_W   = 3,
   parameter int TIMEOUT = 4096,
   parameter int TO_W    = 13
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               loop_mode_i,
   output logic [IDX_W-1:0]   vec_addr_o,
   input  logic [127:0]       vec_message_i,
   input  logic [255:0]       vec_key_i,
   input  logic [7:0]         vec_nk_i,
   input  logic [127:0]       vec_expected_i,
   output logic               dut_reset_o,
   output logic [127:0]       dut_message_o,
   output logic [255:0]       dut_key_o,
   output logic [7:0]         dut_nk_o,
   input  logic               enc_valid_i,
   input  logic               dec_valid_i,
   input  logic [127:0]       dut_data_i,
   output logic [NUM_VEC-1:0] enc_pass_o,
   output logic [NUM_VEC-1:0] dec_pass_o,
   output logic [NUM_VEC-1:0] timeout_flags_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               all_pass_o,
   output logic               error_sticky_o,
   output logic [15:0]        iter_count_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_RUN,
      S_NEXT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               loop_q, loop_d;
   logic [127:0]       msg_q, msg_d;
   logic [255:0]       key_q, key_d;
   logic [7:0]         nk_q, nk_d;
   logic [127:0]       exp_q, exp_d;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic               enc_seen_q, enc_seen_d;
   logic [NUM_VEC-1:0] enc_pass_q, enc_pass_d;
   logic [NUM_VEC-1:0] dec_pass_q, dec_pass_d;
   logic [NUM_VEC-1:0] to_flags_q, to_flags_d;
   logic               err_q, err_d;
   logic [15:0]        iter_q, iter_d;
   logic               all_pass_q, all_pass_d;

   logic enc_match;
   logic dec_match;

   assign enc_match = (dut_data_i == exp_q);
   assign dec_match = (dut_data_i == msg_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      loop_d     = loop_q;
      msg_d      = msg_q;
      key_d      = key_q;
      nk_d       = nk_q;
      exp_d      = exp_q;
      to_cnt_d   = to_cnt_q;
      enc_seen_d = enc_seen_q;
      enc_pass_d = enc_pass_q;
      dec_pass_d = dec_pass_q;
      to_flags_d = to_flags_q;
      err_d      = err_q;
      iter_d     = iter_q;
      // Follows the bitmaps one cycle late.
      all_pass_d = (&enc_pass_q) & (&dec_pass_q) & ~(|to_flags_q);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               enc_pass_d = '0;
               dec_pass_d = '0;
               to_flags_d = '0;
               err_d      = 1'b0;
               iter_d     = '0;
               idx_d      = '0;
               loop_d     = loop_mode_i;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            // Memory data for idx_q is valid in this cycle.
            msg_d      = vec_message_i;
            key_d      = vec_key_i;
            nk_d       = vec_nk_i;
            exp_d      = vec_expected_i;
            to_cnt_d   = '0;
            enc_seen_d = 1'b0;
            state_d    = S_RUN;
         end
         S_RUN: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (enc_valid_i) begin
               enc_pass_d[idx_q] = enc_match;
               enc_seen_d        = 1'b1;
               if (!enc_match) err_d = 1'b1;
            end
            if (dec_valid_i) begin
               dec_pass_d[idx_q] = dec_match;
               // A decrypt result with no ciphertext yet seen is a protocol error.
               if (!dec_match || !(enc_seen_q || enc_valid_i)) err_d = 1'b1;
               state_d = S_NEXT;
            end else if (to_cnt_q == TO_LAST) begin
               to_flags_d[idx_q] = 1'b1;
               err_d             = 1'b1;
               state_d           = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q != LAST_IDX) begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_FETCH;
            end else if (loop_q) begin
               // New pass: fresh bitmaps, but error_sticky survives for soak reporting.
               if (iter_q != 16'hFFFF) iter_d = iter_q + 16'd1;
               enc_pass_d = '0;
               dec_pass_d = '0;
               to_flags_d = '0;
               idx_d      = '0;
               state_d    = S_FETCH;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         loop_q     <= 1'b0;
         msg_q      <= '0;
         key_q      <= '0;
         nk_q       <= '0;
         exp_q      <= '0;
         to_cnt_q   <= '0;
         enc_seen_q <= 1'b0;
         enc_pass_q <= '0;
         dec_pass_q <= '0;
         to_flags_q <= '0;
         err_q      <= 1'b0;
         iter_q     <= '0;
         all_pass_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         loop_q     <= loop_d;
         msg_q      <= msg_d;
         key_q      <= key_d;
         nk_q       <= nk_d;
         exp_q      <= exp_d;
         to_cnt_q   <= to_cnt_d;
         enc_seen_q <= enc_seen_d;
         enc_pass_q <= enc_pass_d;
         dec_pass_q <= dec_pass_d;
         to_flags_q <= to_flags_d;
         err_q      <= err_d;
         iter_q     <= iter_d;
         all_pass_q <= all_pass_d;
      end
   end

   // The SPI side is released only while a vector is running. This also
   // gives at least one reset cycle between vectors.
   assign dut_reset_o     = (state_q != S_RUN);
   assign vec_addr_o      = idx_q;
   assign dut_message_o   = msg_q;
   assign dut_key_o       = key_q;
   assign dut_nk_o        = nk_q;
   assign enc_pass_o      = enc_pass_q;
   assign dec_pass_o      = dec_pass_q;
   assign timeout_flags_o = to_flags_q;
   assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o          = (state_q == S_DONE);
   assign all_pass_o      = all_pass_q;
   assign error_sticky_o  = err_q;
   assign iter_count_o    = iter_q;

endmodule
